dma_bus_arbiter: RTL and testbench

Shares the single external memory bus between the 6502 core and one DMA requester by cycle stealing. The core owns the bus by default. A DMA requester gets whole bus cycles while the core is held via `cpu_rdy`. A burst limit guarantees the core forward progress. The block sits between the core's address/data/`read_en` pins and the memory system.

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_burst_counter.sv | 30 +++
 rtl/dma_bus_arbiter.sv | 117 +++++++++++
 tb/tb_dma_bus_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the DMA/core bus arbiter.
package arb_pkg;

  // Width of the DMA burst counter; the burst limit stays below 2**ARB_CNT_W.
  localparam int ARB_CNT_W = 4;

  // Bus ownership states of the arbiter.
  typedef enum logic [1:0] {
    ARB_CPU      = 2'd0,
    ARB_DMA      = 2'd1,
    ARB_CPU_FAIR = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_burst_counter.sv
// Counts granted DMA cycles in the current burst and flags the last one allowed.
module arb_burst_counter
  import arb_pkg::*;
(
  input  logic                 ph2,
  input  logic                 resetb,
  input  logic                 clear,
  input  logic                 increment,
  input  logic [ARB_CNT_W-1:0] limit,
  output logic [ARB_CNT_W-1:0] count,
  output logic                 at_limit
);

  // Burst count register: reset, clear on burst exit, step per granted cycle.
  always_ff @(posedge ph2) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its inputs, independent of statement order.
    if (!resetb) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (increment) begin
      count <= count + 1'b1;
    end
  end

  // The current grant is the final one the limit allows before a core cycle.
  assign at_limit = ((count + 1'b1) == limit);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Cycle-stealing arbiter sharing the external memory bus between the 6502
// core (default owner) and a single DMA requester, with a burst limit that
// guarantees the core forward progress.
module dma_bus_arbiter
  import arb_pkg::*;
#(
  parameter int DMA_MAX_BURST = 4
) (
  input  logic        ph2,
  input  logic        resetb,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_read_en,
  output logic        cpu_rdy,
  input  logic        dma_req,
  input  logic        dma_last,
  input  logic [15:0] dma_addr,
  input  logic        dma_we,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic [7:0]  dma_rdata,
  output logic        dma_rvalid,
  output logic [15:0] mem_address,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [ARB_CNT_W-1:0] BURST_LIMIT = DMA_MAX_BURST[ARB_CNT_W-1:0];

  arb_state_t           state;
  arb_state_t           next_state;
  logic                 dma_phase;
  logic                 granted;
  logic                 burst_clear;
  logic                 burst_inc;
  logic                 at_limit;
  logic [ARB_CNT_W-1:0] burst_cnt;

  assign dma_phase = (state == ARB_DMA);
  assign granted   = dma_phase && dma_req;

  // Next bus owner; last transfer beats the burst limit, both end the burst.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // next_state unassigned, which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      ARB_CPU:      next_state = dma_req ? ARB_DMA : ARB_CPU;
      ARB_DMA: begin
        if (!dma_req)      next_state = ARB_CPU;
        else if (dma_last) next_state = ARB_CPU;
        else if (at_limit) next_state = ARB_CPU_FAIR;
        else               next_state = ARB_DMA;
      end
      ARB_CPU_FAIR: next_state = ARB_CPU;
      default:      next_state = ARB_CPU;
    endcase
  end

  // State register; reset returns the bus to the core and aborts any burst.
  always_ff @(posedge ph2) begin
    if (!resetb) begin
      state <= ARB_CPU;
    end else begin
      state <= next_state;
    end
  end

  // Counter clears whenever the burst ends and steps on each continuing grant.
  assign burst_clear = (next_state != ARB_DMA);
  assign burst_inc   = granted && (next_state == ARB_DMA);

  arb_burst_counter u_burst_counter (
    .ph2       (ph2),
    .resetb    (resetb),
    .clear     (burst_clear),
    .increment (burst_inc),
    .limit     (BURST_LIMIT),
    .count     (burst_cnt),
    .at_limit  (at_limit)
  );

  // Bus mux and handshakes, decoded from the registered state; reset forces
  // the bus idle and the core running regardless of state.
  always_comb begin
    mem_address = dma_phase ? dma_addr  : cpu_address;
    mem_wdata   = dma_phase ? dma_wdata : cpu_data_out;
    mem_we      = 1'b0;
    if (resetb) begin
      mem_we = dma_phase ? (dma_we && dma_req) : !cpu_read_en;
    end
    cpu_rdy = !resetb || !dma_phase;
    dma_gnt = resetb && granted;
  end

  // Capture read data on a granted DMA read and pulse valid for one cycle.
  always_ff @(posedge ph2) begin
    if (!resetb) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= 8'h00;
    end else begin
      dma_rvalid <= granted && !dma_we;
      if (granted && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

  // A burst in progress never reaches the limit count itself.
  always_ff @(posedge ph2) begin
    if (resetb && dma_phase) begin
      assert (burst_cnt < BURST_LIMIT);
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: a requester model feeds DMA
// transfers, a scoreboard holds the expected bus transactions and read data.
module tb_dma_bus_arbiter;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        last;
  } xfer_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } bus_t;

  logic        ph2;
  logic        resetb;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_out;
  logic        cpu_read_en;
  logic        cpu_rdy;
  logic        dma_req;
  logic        dma_last;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic [15:0] mem_address;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int errors = 0;
  int checks = 0;

  xfer_t      pend[$];     // requester: transfers still to be granted
  bus_t       exp_bus[$];  // scoreboard: expected bus transactions in order
  logic [7:0] exp_rd[$];   // scoreboard: expected captured read data
  logic       rd_due = 1'b0;

  dma_bus_arbiter #(.DMA_MAX_BURST(4)) dut (
    .ph2          (ph2),
    .resetb       (resetb),
    .cpu_address  (cpu_address),
    .cpu_data_out (cpu_data_out),
    .cpu_read_en  (cpu_read_en),
    .cpu_rdy      (cpu_rdy),
    .dma_req      (dma_req),
    .dma_last     (dma_last),
    .dma_addr     (dma_addr),
    .dma_we       (dma_we),
    .dma_wdata    (dma_wdata),
    .dma_gnt      (dma_gnt),
    .dma_rdata    (dma_rdata),
    .dma_rvalid   (dma_rvalid),
    .mem_address  (mem_address),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial begin
    ph2 = 1'b0;
    forever #5 ph2 = ~ph2;
  end

  // Queue a transfer for the requester and its expected bus transaction.
  task automatic push_xfer(input logic [15:0] addr, input logic we,
                           input logic [7:0] wdata, input logic [7:0] rdata,
                           input logic last);
    xfer_t x;
    bus_t  b;
    x = '{addr: addr, we: we, wdata: wdata, rdata: rdata, last: last};
    b = '{addr: addr, we: we, wdata: wdata};
    pend.push_back(x);
    exp_bus.push_back(b);
  endtask

  // One bus cycle: present the head transfer, sample at the falling edge,
  // run the scoreboard, advance the requester on a grant.
  task automatic cycle(output logic gnt, output logic rdy, output logic we,
                       output logic rv, output logic [7:0] rd);
    xfer_t      h;
    bus_t       eb;
    logic [7:0] er;
    logic       rd_next;
    h = '{addr: 16'h0000, we: 1'b1, wdata: 8'h00, rdata: 8'hEE, last: 1'b0};
    if (pend.size() > 0) h = pend[0];
    dma_req   = (pend.size() > 0);
    dma_addr  = h.addr;
    dma_we    = h.we;
    dma_wdata = h.wdata;
    dma_last  = h.last;
    mem_rdata = h.rdata;
    @(negedge ph2);
    gnt = dma_gnt;
    rdy = cpu_rdy;
    we  = mem_we;
    rv  = dma_rvalid;
    rd  = dma_rdata;
    checks++;
    if (dma_rvalid !== rd_due) begin
      errors++;
      $display("FAIL rvalid_timing: got %b expected %b", dma_rvalid, rd_due);
    end
    if (dma_rvalid === 1'b1) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: got %h expected no read", dma_rdata);
      end else begin
        er = exp_rd.pop_front();
        if (dma_rdata !== er) begin
          errors++;
          $display("FAIL rdata: got %h expected %h", dma_rdata, er);
        end
      end
    end
    rd_next = 1'b0;
    if (dma_gnt === 1'b1) begin
      checks++;
      if (exp_bus.size() == 0 || pend.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got gnt=1 expected no grant");
      end else begin
        eb = exp_bus.pop_front();
        if ({mem_address, mem_we, mem_wdata} !== {eb.addr, eb.we, eb.wdata}) begin
          errors++;
          $display("FAIL dma_bus: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                   mem_address, mem_we, mem_wdata, eb.addr, eb.we, eb.wdata);
        end
        if (!h.we) begin
          exp_rd.push_back(h.rdata);
          rd_next = 1'b1;
        end
        void'(pend.pop_front());
      end
    end
    rd_due = rd_next;
    @(posedge ph2);
    #1;
  endtask

  // Everything queued must have been transferred.
  task automatic check_drained(input string name);
    checks++;
    if (exp_bus.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d bus/%0d rd pending expected 0/0",
               name, exp_bus.size(), exp_rd.size());
    end
  endtask

  task automatic test_reset();
    logic g, r, w, v;
    logic [7:0] d;
    cpu_read_en = 1'b0;
    push_xfer(16'h0100, 1'b1, 8'h11, 8'h00, 1'b1);
    @(posedge ph2);
    #1;
    for (int i = 0; i < 2; i++) begin
      cycle(g, r, w, v, d);
      checks++;
      if ({r, g, w} !== 3'b100) begin
        errors++;
        $display("FAIL reset_outputs: got rdy/gnt/we=%b%b%b expected 100", r, g, w);
      end
    end
    resetb = 1'b1;
    cycle(g, r, w, v, d);
    checks++;
    if ({r, g, w, v, d} !== {4'b1010, 8'h00}) begin
      errors++;
      $display("FAIL reset_first_cpu: got rdy/gnt/we/rv=%b%b%b%b rdata=%h expected 1010 00",
               r, g, w, v, d);
    end
    cycle(g, r, w, v, d);
    checks++;
    if ({r, g} !== 2'b01) begin
      errors++;
      $display("FAIL reset_grant: got rdy/gnt=%b%b expected 01", r, g);
    end
    cycle(g, r, w, v, d);
    check_drained("reset");
  endtask

  task automatic test_passthrough();
    logic g, r, w, v;
    logic [7:0] d;
    cpu_address  = 16'h01FF;
    cpu_read_en  = 1'b0;
    cpu_data_out = 8'h42;
    cycle(g, r, w, v, d);
    checks++;
    if ({mem_address, w, mem_wdata, r, g} !== {16'h01FF, 1'b1, 8'h42, 2'b10}) begin
      errors++;
      $display("FAIL passthrough_write: got addr=%h we=%b wdata=%h rdy=%b gnt=%b expected 01ff 1 42 1 0",
               mem_address, w, mem_wdata, r, g);
    end
    cpu_address = 16'hFFFC;
    cpu_read_en = 1'b1;
    cycle(g, r, w, v, d);
    checks++;
    if ({mem_address, w, r} !== {16'hFFFC, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL passthrough_read: got addr=%h we=%b rdy=%b expected fffc 0 1",
               mem_address, w, r);
    end
  endtask

  task automatic test_single_write();
    logic g, r, w, v;
    logic [7:0] d;
    bit exp_g[3] = '{0, 1, 0};
    bit exp_r[3] = '{1, 0, 1};
    bit exp_w[3] = '{0, 1, 0};
    cpu_read_en = 1'b1;
    push_xfer(16'h0200, 1'b1, 8'hA5, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(g, r, w, v, d);
      checks++;
      if ({g, r, w} !== {exp_g[i], exp_r[i], exp_w[i]}) begin
        errors++;
        $display("FAIL single_write_c%0d: got gnt/rdy/we=%b%b%b expected %b%b%b",
                 i, g, r, w, exp_g[i], exp_r[i], exp_w[i]);
      end
    end
    check_drained("single_write");
  endtask

  // Six transfers, limit 4: four grants, the fair core cycle, the ordinary
  // core cycle every DMA entry needs, then the remaining two grants.
  task automatic test_burst_fair();
    logic g, r, w, v;
    logic [7:0] d;
    bit exp_g[10] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      push_xfer(16'h0400 + 16'(i), 1'b1, 8'h30 + 8'(i), 8'h00, i == 5);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(g, r, w, v, d);
      checks++;
      if ({g, r} !== {exp_g[i], !exp_g[i]}) begin
        errors++;
        $display("FAIL burst_fair_c%0d: got gnt/rdy=%b%b expected %b%b",
                 i, g, r, exp_g[i], !exp_g[i]);
      end
    end
    check_drained("burst_fair");
  endtask

  task automatic test_dma_read();
    logic g, r, w, v;
    logic [7:0] d;
    push_xfer(16'h0300, 1'b0, 8'h00, 8'h3C, 1'b1);
    cycle(g, r, w, v, d);
    cycle(g, r, w, v, d);
    checks++;
    if ({g, w, v} !== 3'b100) begin
      errors++;
      $display("FAIL read_grant: got gnt/we/rv=%b%b%b expected 100", g, w, v);
    end
    cycle(g, r, w, v, d);
    checks++;
    if ({v, d, r} !== {1'b1, 8'h3C, 1'b1}) begin
      errors++;
      $display("FAIL read_data: got rv=%b rdata=%h rdy=%b expected 1 3c 1", v, d, r);
    end
    cycle(g, r, w, v, d);
    checks++;
    if ({v, d} !== {1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL read_hold: got rv=%b rdata=%h expected 0 3c", v, d);
    end
    check_drained("dma_read");
  endtask

  // Reset during the third burst cycle, then a fresh full burst whose final
  // transfer coincides with the limit, then an immediate new request.
  task automatic test_abort();
    logic g, r, w, v;
    logic [7:0] d;
    bit exp_g[8] = '{0, 1, 1, 1, 1, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      push_xfer(16'h0500 + 16'(i), 1'b0, 8'h00, 8'h80 + 8'(i), i == 5);
    end
    push_xfer(16'h0600, 1'b1, 8'h77, 8'h00, 1'b1);
    cycle(g, r, w, v, d);
    cycle(g, r, w, v, d);
    cycle(g, r, w, v, d);
    resetb = 1'b0;
    cycle(g, r, w, v, d);
    checks++;
    if ({g, r, w} !== 3'b010) begin
      errors++;
      $display("FAIL abort_reset_cycle: got gnt/rdy/we=%b%b%b expected 010", g, r, w);
    end
    resetb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(g, r, w, v, d);
      checks++;
      if ({g, r} !== {exp_g[i], !exp_g[i]}) begin
        errors++;
        $display("FAIL abort_after_c%0d: got gnt/rdy=%b%b expected %b%b",
                 i, g, r, exp_g[i], !exp_g[i]);
      end
      if (i == 0) begin
        checks++;
        if ({v, d} !== {1'b0, 8'h00}) begin
          errors++;
          $display("FAIL abort_cleared: got rv=%b rdata=%h expected 0 00", v, d);
        end
      end
    end
    cycle(g, r, w, v, d);
    check_drained("abort");
  endtask

  task automatic test_dead_cycle();
    logic g, r, w, v;
    logic [7:0] d;
    bit exp_r[4] = '{1, 0, 0, 1};
    bit exp_w[4] = '{1, 1, 0, 1};
    cpu_read_en = 1'b0;
    push_xfer(16'h0700, 1'b1, 8'h5A, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(g, r, w, v, d);
      checks++;
      if ({r, w} !== {exp_r[i], exp_w[i]}) begin
        errors++;
        $display("FAIL dead_cycle_c%0d: got rdy/we=%b%b expected %b%b",
                 i, r, w, exp_r[i], exp_w[i]);
      end
    end
    check_drained("dead_cycle");
  endtask

  initial begin
    resetb       = 1'b0;
    cpu_address  = 16'h0000;
    cpu_data_out = 8'h00;
    cpu_read_en  = 1'b1;
    dma_req      = 1'b0;
    dma_last     = 1'b0;
    dma_addr     = 16'h0000;
    dma_we       = 1'b1;
    dma_wdata    = 8'h00;
    mem_rdata    = 8'h00;
    test_reset();
    test_passthrough();
    test_single_write();
    test_burst_fair();
    test_dma_read();
    test_abort();
    test_dead_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
